// File: rtl/elixirchip_es1_spu_op_counter.sv
// Programmable modulo counter with wrap strobe and a LATENCY-deep cke-gated output pipeline.
// Define ELIXIRCHIP_ES1_SPU_OP_COUNTER_OVF_EN to build the carry-out strobe on m_overflow.
module elixirchip_es1_spu_op_counter #(
    parameter int  LATENCY    = 1,
    parameter int  DATA_BITS  = 8,
    parameter type data_t     = logic [DATA_BITS-1:0],
    parameter      DEVICE     = "RTL",
    parameter      SIMULATION = "false",
    parameter      DEBUG      = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  logic  s_valid,
    input  logic  s_load,
    input  data_t s_load_data,
    input  data_t s_step,
    input  data_t s_limit,
    output data_t m_data,
    output logic  m_wrap,
    output logic  m_overflow
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be >= 1");
    end
    if (DEVICE == "") begin : g_bad_device
        $error("DEVICE must name a target");
    end
    if ((SIMULATION != "true" && SIMULATION != "false") ||
        (DEBUG != "true" && DEBUG != "false")) begin : g_bad_switch
        $error("SIMULATION and DEBUG must be \"true\" or \"false\"");
    end

    // Index 0 is the stage-1 register set; index 0 of data_p is the live count.
    data_t data_p [LATENCY];
    logic  wrap_p [LATENCY];

    data_t cnt;
    data_t cnt_next;
    logic  wrap_next;

    assign cnt = data_p[0];

`ifdef ELIXIRCHIP_ES1_SPU_OP_COUNTER_OVF_EN
    logic                 ovf_p [LATENCY];
    logic                 ovf_next;
    logic [DATA_BITS:0]   sum;

    always_comb begin
        sum       = {1'b0, cnt} + {1'b0, s_step};
        cnt_next  = cnt;
        wrap_next = 1'b0;
        ovf_next  = 1'b0;
        if (s_valid) begin
            if (s_load) begin
                cnt_next = s_load_data;
            end else if (cnt >= s_limit) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = sum[DATA_BITS-1:0];
                ovf_next = sum[DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) ovf_p[i] <= 1'b0;
        end else if (cke) begin
            ovf_p[0] <= ovf_next;
            for (int i = 1; i < LATENCY; i++) ovf_p[i] <= ovf_p[i-1];
        end
    end

    assign m_overflow = ovf_p[LATENCY-1];
`else
    always_comb begin
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (s_valid) begin
            if (s_load) begin
                cnt_next = s_load_data;
            end else if (cnt >= s_limit) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = cnt + s_step;
            end
        end
    end

    assign m_overflow = 1'b0;
`endif

    // Stage 1 takes the next count; later stages shift only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_p[i] <= '0;
                wrap_p[i] <= 1'b0;
            end
        end else if (cke) begin
            data_p[0] <= cnt_next;
            wrap_p[0] <= wrap_next;
            for (int i = 1; i < LATENCY; i++) begin
                data_p[i] <= data_p[i-1];
                wrap_p[i] <= wrap_p[i-1];
            end
        end
    end

    assign m_data = data_p[LATENCY-1];
    assign m_wrap = wrap_p[LATENCY-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_counter.sv
// Directed bench for elixirchip_es1_spu_op_counter: a LATENCY=1 and a LATENCY=3 instance share stimulus.
module tb_elixirchip_es1_spu_op_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic       s_valid;
    logic       s_load;
    logic [7:0] s_load_data;
    logic [7:0] s_step;
    logic [7:0] s_limit;
    logic [7:0] m_data,  m_data3;
    logic       m_wrap,  m_wrap3;
    logic       m_overflow, m_overflow3;

    int vectors = 0;
    int errors  = 0;

`ifdef ELIXIRCHIP_ES1_SPU_OP_COUNTER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_counter #(.LATENCY(1), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_load(s_load),
        .s_load_data(s_load_data), .s_step(s_step), .s_limit(s_limit),
        .m_data(m_data), .m_wrap(m_wrap), .m_overflow(m_overflow)
    );

    elixirchip_es1_spu_op_counter #(.LATENCY(3), .DATA_BITS(8)) dut3 (
        .clk(clk), .reset(reset), .cke(cke), .s_valid(s_valid), .s_load(s_load),
        .s_load_data(s_load_data), .s_step(s_step), .s_limit(s_limit),
        .m_data(m_data3), .m_wrap(m_wrap3), .m_overflow(m_overflow3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cke   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid     = 1'($urandom);
            s_load      = 1'($urandom);
            s_load_data = 8'($urandom);
            s_step      = 8'($urandom);
            s_limit     = 8'($urandom);
            tick();
            vectors++;
            if ({m_data, m_wrap, m_overflow, m_data3, m_wrap3, m_overflow3} !== 20'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got d=%h w=%b o=%b d3=%h w3=%b o3=%b want all 0",
                         i, m_data, m_wrap, m_overflow, m_data3, m_wrap3, m_overflow3);
            end
        end
        reset   = 1'b0;
        s_valid = 1'b0;
        s_load  = 1'b0;
        tick();
        vectors++;
        if ({m_data, m_wrap, m_overflow, m_data3, m_wrap3, m_overflow3} !== 20'h0) begin
            errors++;
            $display("FAIL reset_release got d=%h w=%b o=%b d3=%h want all 0",
                     m_data, m_wrap, m_overflow, m_data3);
        end
    endtask

    task automatic test_modulo();
        logic [7:0] exp_d [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        logic       exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        cke = 1'b1; s_valid = 1'b1; s_load = 1'b0; s_step = 8'd1; s_limit = 8'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (m_data !== exp_d[i] || m_wrap !== exp_w[i] || m_overflow !== 1'b0) begin
                errors++;
                $display("FAIL modulo[%0d] got d=%h w=%b o=%b want d=%h w=%b o=0",
                         i, m_data, m_wrap, m_overflow, exp_d[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        // Counter is at 0; bring it to 3 == s_limit so a plain step would wrap.
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (m_data !== 8'd3) begin
            errors++;
            $display("FAIL load_setup got %h want 03", m_data);
        end
        s_load = 1'b1; s_load_data = 8'h55;
        tick();
        vectors++;
        if (m_data !== 8'h55 || m_wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_priority got d=%h w=%b want d=55 w=0", m_data, m_wrap);
        end
        s_load = 1'b0; s_step = 8'd1; s_limit = 8'h60;
        tick();
        vectors++;
        if (m_data !== 8'h56 || m_wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_next got d=%h w=%b want d=56 w=0", m_data, m_wrap);
        end
    endtask

    task automatic test_hold();
        logic [7:0] cnt_m  = 8'h00;
        logic       wrap_m = 1'b0;
        logic [7:0] prev_d;
        logic       prev_w;
        cke = 1'b1; s_valid = 1'b1; s_load = 1'b1; s_load_data = 8'h00;
        tick();
        s_load = 1'b0; s_step = 8'd3; s_limit = 8'h20;
        for (int i = 0; i < 60; i++) begin
            prev_d  = m_data;
            prev_w  = m_wrap;
            cke     = ($urandom_range(0, 9) != 0);
            s_valid = 1'($urandom);
            tick();
            if (cke) begin
                if (s_valid) begin
                    if (cnt_m >= s_limit) begin
                        cnt_m = 8'h00; wrap_m = 1'b1;
                    end else begin
                        cnt_m = cnt_m + s_step; wrap_m = 1'b0;
                    end
                end else begin
                    wrap_m = 1'b0;
                end
                vectors++;
                if (m_data !== cnt_m || m_wrap !== wrap_m) begin
                    errors++;
                    $display("FAIL hold_step[%0d] got d=%h w=%b want d=%h w=%b",
                             i, m_data, m_wrap, cnt_m, wrap_m);
                end
            end else begin
                vectors++;
                if (m_data !== prev_d || m_wrap !== prev_w) begin
                    errors++;
                    $display("FAIL hold_frozen[%0d] got d=%h w=%b want d=%h w=%b",
                             i, m_data, m_wrap, prev_d, prev_w);
                end
            end
        end
        // A wrap strobe must persist across cke=0 cycles.
        cke = 1'b1; s_valid = 1'b1; s_load = 1'b1; s_load_data = 8'h20;
        tick();
        s_load = 1'b0;
        tick();
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (m_wrap !== 1'b1 || m_data !== 8'h00) begin
                errors++;
                $display("FAIL wrap_stretch[%0d] got d=%h w=%b want d=00 w=1", i, m_data, m_wrap);
            end
        end
        cke = 1'b1;
        tick();
        vectors++;
        if (m_wrap !== 1'b0 || m_data !== 8'h03) begin
            errors++;
            $display("FAIL wrap_release got d=%h w=%b want d=03 w=0", m_data, m_wrap);
        end
    endtask

    task automatic test_overflow();
        cke = 1'b1; s_valid = 1'b1; s_load = 1'b1; s_load_data = 8'hFE;
        tick();
        s_load = 1'b0; s_step = 8'd3; s_limit = 8'hFF;
        tick();
        vectors++;
        if (m_data !== 8'h01 || m_wrap !== 1'b0 || m_overflow !== OVF_EXP) begin
            errors++;
            $display("FAIL overflow got d=%h w=%b o=%b want d=01 w=0 o=%b",
                     m_data, m_wrap, m_overflow, OVF_EXP);
        end
        tick();
        vectors++;
        if (m_data !== 8'h04 || m_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got d=%h o=%b want d=04 o=0", m_data, m_overflow);
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp_d [6] = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13};
        // Reset mid-count flushes everything in flight.
        cke = 1'b1; reset = 1'b1; s_valid = 1'b1;
        tick();
        vectors++;
        if (m_data3 !== 8'h00 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL midcount_reset got d=%h d3=%h want 00", m_data, m_data3);
        end
        reset = 1'b0; s_valid = 1'b0;
        tick();
        s_valid = 1'b1; s_load = 1'b1; s_load_data = 8'h10;
        for (int i = 0; i < 6; i++) begin
            tick();
            s_load = 1'b0; s_step = 8'd1; s_limit = 8'hFF;
            vectors++;
            if (m_data3 !== exp_d[i] || m_wrap3 !== 1'b0) begin
                errors++;
                $display("FAIL latency[%0d] got d3=%h w3=%b want d3=%h w3=0",
                         i, m_data3, m_wrap3, exp_d[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; s_valid = 1'b0; s_load = 1'b0;
        s_load_data = '0; s_step = '0; s_limit = '0;
        test_reset();
        test_modulo();
        test_load_priority();
        test_hold();
        test_overflow();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
